// File: rtl/mux8_rr_sched_if.sv
// Handshake bundle between the requesters/consumer and the 8:1 mux scheduler.
// The master side drives requests and downstream ready; the slave side is the scheduler.
interface mux8_rr_sched_if;
    logic [7:0] req;
    logic       out_ready;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       out_valid;
    logic       busy;

    modport master (
        output req,
        output out_ready,
        input  sel,
        input  gnt,
        input  out_valid,
        input  busy
    );

    modport slave (
        input  req,
        input  out_ready,
        output sel,
        output gnt,
        output out_valid,
        output busy
    );
endinterface

// File: rtl/mux8_rr_sched.sv
// Round-robin scheduler sharing one 8:1 single-bit mux among 8 requesters.
// A grant lasts until its requester drops req or MAX_HOLD beats are accepted;
// it then rotates straight to the next waiting requester with no idle bubble.
module mux8_rr_sched #(
    parameter int MAX_HOLD = 4,
    parameter int CNTW     = 4
) (
    input  logic             clk,
    input  logic             rst,
    mux8_rr_sched_if.slave   bus
);

    localparam logic [0:0]      S_IDLE    = 1'b0;
    localparam logic [0:0]      S_GRANT   = 1'b1;
    localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(MAX_HOLD - 1);

    logic [0:0]      state;
    logic [2:0]      sel_q;
    logic [2:0]      ptr;
    logic [7:0]      gnt_q;
    logic [CNTW-1:0] cnt;
    logic            busy_q;

    logic            valid;
    logic            beat;
    logic            rel;
    logic            any_req;
    logic [2:0]      next_start;
    logic [2:0]      pick_idle;
    logic [2:0]      pick_next;

    // First index at or after p (wrapping mod 8) whose bit in v is set.
    function automatic logic [2:0] pick(input logic [2:0] p, input logic [7:0] v);
        logic [2:0] idx;
        logic [2:0] res;
        logic       found;
        res   = p;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = p + 3'(i);
            if (!found && v[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    assign valid      = (state == S_GRANT) && bus.req[sel_q];
    assign beat       = valid && bus.out_ready;
    assign any_req    = |bus.req;
    assign next_start = sel_q + 3'd1;

    // Release when the owner lets go, or when the last allowed beat is accepted.
    always_comb begin
        rel       = 1'b0;
        pick_idle = pick(ptr, bus.req);
        pick_next = pick(next_start, bus.req);
        if (state == S_GRANT) begin
            rel = !bus.req[sel_q] || (beat && (cnt == LAST_BEAT));
        end
    end

    // Grant state machine: start from ptr when idle, rotate past the owner on release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            sel_q  <= 3'd0;
            ptr    <= 3'd0;
            gnt_q  <= 8'h00;
            cnt    <= '0;
            busy_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        state  <= S_GRANT;
                        sel_q  <= pick_idle;
                        gnt_q  <= 8'b1 << pick_idle;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                S_GRANT: begin
                    if (rel) begin
                        ptr <= next_start;
                        cnt <= '0;
                        if (any_req) begin
                            sel_q <= pick_next;
                            gnt_q <= 8'b1 << pick_next;
                        end else begin
                            state  <= S_IDLE;
                            gnt_q  <= 8'h00;
                            busy_q <= 1'b0;
                        end
                    end else if (beat) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    gnt_q  <= 8'h00;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sel       = sel_q;
    assign bus.gnt       = gnt_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = valid;

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Directed testbench for mux8_rr_sched (MAX_HOLD=4).
// Observed outputs are packed as {sel, gnt, out_valid, busy} and compared to hand-derived values.
module tb_mux8_rr_sched;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mux8_rr_sched_if bus ();

    mux8_rr_sched #(
        .MAX_HOLD (4),
        .CNTW     (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge, where outputs are sampled and inputs changed.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Synchronous-looking reset pulse spanning one edge.
    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [12:0] obs;
        logic [12:0] exp;
        bus.req       = 8'h00;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        tick();
        tick();
        obs = {bus.sel, bus.gnt, bus.out_valid, bus.busy};
        exp = {3'd0, 8'h00, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL reset_state got=%h want=%h", obs, exp);
        end
        rst           = 1'b0;
        bus.req       = 8'hFF;
        bus.out_ready = 1'b1;
        tick();
        obs = {bus.sel, bus.gnt, bus.out_valid, bus.busy};
        exp = {3'd0, 8'h01, 1'b1, 1'b1};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL reset_first_grant got=%h want=%h", obs, exp);
        end
        tick();
        // Assert reset between edges; outputs must clear without waiting for a clock.
        #2;
        rst = 1'b1;
        #1;
        obs = {bus.sel, bus.gnt, bus.out_valid, bus.busy};
        exp = {3'd0, 8'h00, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL reset_mid_grant got=%h want=%h", obs, exp);
        end
        tick();
        rst = 1'b0;
        tick();
        obs = {bus.sel, bus.gnt, bus.out_valid, bus.busy};
        exp = {3'd0, 8'h01, 1'b1, 1'b1};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL reset_regrant_idx0 got=%h want=%h", obs, exp);
        end
        bus.req = 8'h00;
        tick();
    endtask

    task automatic test_single();
        logic [12:0] obs;
        logic [12:0] exp;
        pulse_reset();
        bus.req       = 8'h08;
        bus.out_ready = 1'b1;
        tick();
        exp = {3'd3, 8'h08, 1'b1, 1'b1};
        for (int k = 1; k <= 12; k++) begin
            obs = {bus.sel, bus.gnt, bus.out_valid, bus.busy};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL single_cycle%0d got=%h want=%h", k, obs, exp);
            end
            tick();
        end
    endtask

    task automatic test_drain(input logic [2:0] last_sel);
        logic [12:0] obs;
        logic [12:0] exp;
        bus.req = 8'h00;
        tick();
        exp = {last_sel, 8'h00, 1'b0, 1'b0};
        for (int k = 0; k < 2; k++) begin
            obs = {bus.sel, bus.gnt, bus.out_valid, bus.busy};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL drain_idle%0d got=%h want=%h", k, obs, exp);
            end
            tick();
        end
    endtask

    task automatic test_round_robin();
        logic [12:0] obs;
        logic [12:0] exp;
        logic [2:0]  esel;
        pulse_reset();
        bus.req       = 8'h81;
        bus.out_ready = 1'b1;
        tick();
        for (int k = 1; k <= 16; k++) begin
            esel = (((k - 1) / 4) % 2 == 0) ? 3'd0 : 3'd7;
            exp  = {esel, 8'b1 << esel, 1'b1, 1'b1};
            obs  = {bus.sel, bus.gnt, bus.out_valid, bus.busy};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL rr_cycle%0d got=%h want=%h", k, obs, exp);
            end
            tick();
        end
        bus.req = 8'h00;
        tick();
    endtask

    task automatic test_backpressure();
        logic [12:0] obs;
        logic [12:0] exp;
        pulse_reset();
        bus.req       = 8'h44;
        bus.out_ready = 1'b0;
        tick();
        exp = {3'd2, 8'h04, 1'b1, 1'b1};
        for (int k = 0; k < 10; k++) begin
            obs = {bus.sel, bus.gnt, bus.out_valid, bus.busy};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL bp_stall%0d got=%h want=%h", k, obs, exp);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            obs = {bus.sel, bus.gnt, bus.out_valid, bus.busy};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL bp_beat%0d got=%h want=%h", k + 1, obs, exp);
            end
        end
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            obs = {bus.sel, bus.gnt, bus.out_valid, bus.busy};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL bp_hold%0d got=%h want=%h", k, obs, exp);
            end
        end
        bus.out_ready = 1'b1;
        tick();
        obs = {bus.sel, bus.gnt, bus.out_valid, bus.busy};
        exp = {3'd6, 8'h40, 1'b1, 1'b1};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL bp_rotate got=%h want=%h", obs, exp);
        end
        bus.req       = 8'h00;
        bus.out_ready = 1'b0;
        tick();
    endtask

    task automatic test_early_drop();
        logic [12:0] obs;
        logic [12:0] exp;
        pulse_reset();
        bus.req       = 8'h20;
        bus.out_ready = 1'b1;
        tick();
        obs = {bus.sel, bus.gnt, bus.out_valid, bus.busy};
        exp = {3'd5, 8'h20, 1'b1, 1'b1};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL drop_grant5 got=%h want=%h", obs, exp);
        end
        tick();
        tick();
        bus.req = 8'h06;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drop_valid_low got=%b want=0", bus.out_valid);
        end
        tick();
        exp = {3'd1, 8'h02, 1'b1, 1'b1};
        for (int k = 0; k < 4; k++) begin
            obs = {bus.sel, bus.gnt, bus.out_valid, bus.busy};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL drop_new_owner%0d got=%h want=%h", k, obs, exp);
            end
            tick();
        end
        obs = {bus.sel, bus.gnt, bus.out_valid, bus.busy};
        exp = {3'd2, 8'h04, 1'b1, 1'b1};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL drop_fresh_count got=%h want=%h", obs, exp);
        end
        bus.req = 8'h04;
    endtask

    // Run each scenario in order, then report.
    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.req       = 8'h00;
        bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_drain(3'd3);
        test_round_robin();
        test_backpressure();
        test_early_drop();
        test_drain(3'd2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
